// File: rtl/clint_smp.sv
// Core-local interruptor: one shared 64-bit mtime with per-hart mtimecmp/msip and interrupt lines.
// Define CLINT_MTIME_WR_EN to make the mtime halves writable; otherwise mtime is read-only.
module clint_smp #(
  parameter int N_HARTS  = 1,
  parameter int TICK_DIV = 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic               w_req_we,
  input  logic               w_req_re,
  input  logic [15:0]        w_req_addr,
  input  logic [31:0]        w_req_wdata,
  output logic [31:0]        r_rdata,
  output logic               r_rvalid,
  output logic [N_HARTS-1:0] w_mtip,
  output logic [N_HARTS-1:0] w_msip,
  output logic [63:0]        w_mtime
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0]        r_presc;
  logic [63:0]        r_mtime;
  logic [N_HARTS-1:0] r_msip;
  logic [N_HARTS-1:0] r_mtip;
  logic [63:0]        r_mtimecmp [N_HARTS];

  logic        w_tick;
  logic [63:0] w_mtime_inc;
  logic [63:0] w_mtime_next;
  logic        w_sel_msip;
  logic        w_sel_cmp;
  logic        w_sel_mtl;
  logic        w_sel_mth;
  logic        w_rd_fire;
  logic [31:0] w_rd_val;
  logic        w_unused;

  // Address decode; per-hart match happens below, so absent harts simply never hit.
  assign w_sel_msip = (w_req_addr[15:6] == 10'h000);
  assign w_sel_cmp  = (w_req_addr[15:7] == 9'h080);
  assign w_sel_mtl  = (w_req_addr[15:2] == 14'h2FFE);
  assign w_sel_mth  = (w_req_addr[15:2] == 14'h2FFF);
  assign w_unused   = ^w_req_addr[1:0];

  assign w_tick      = (r_presc == DIV_LAST);
  assign w_mtime_inc = r_mtime + {63'd0, w_tick};

  always_comb begin
    w_mtime_next = w_mtime_inc;
`ifdef CLINT_MTIME_WR_EN
    // Written half wins; the other half keeps its incremented value including carry.
    if (w_req_we && w_sel_mtl) w_mtime_next[31:0]  = w_req_wdata;
    if (w_req_we && w_sel_mth) w_mtime_next[63:32] = w_req_wdata;
`endif
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_presc <= 16'd0;
      r_mtime <= 64'd0;
    end else begin
      r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      r_mtime <= w_mtime_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_HARTS; gi++) begin : g_hart
      logic w_msip_we;
      logic w_cmp_lo_we;
      logic w_cmp_hi_we;

      assign w_msip_we   = w_req_we && w_sel_msip && (w_req_addr[5:2] == 4'(gi));
      assign w_cmp_lo_we = w_req_we && w_sel_cmp && (w_req_addr[6:3] == 4'(gi)) && !w_req_addr[2];
      assign w_cmp_hi_we = w_req_we && w_sel_cmp && (w_req_addr[6:3] == 4'(gi)) &&  w_req_addr[2];

      always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
          r_msip[gi]     <= 1'b0;
          r_mtimecmp[gi] <= 64'hFFFF_FFFF_FFFF_FFFF;
          r_mtip[gi]     <= 1'b0;
        end else begin
          if (w_msip_we)   r_msip[gi]            <= w_req_wdata[0];
          if (w_cmp_lo_we) r_mtimecmp[gi][31:0]  <= w_req_wdata;
          if (w_cmp_hi_we) r_mtimecmp[gi][63:32] <= w_req_wdata;
          r_mtip[gi] <= (r_mtime >= r_mtimecmp[gi]);
        end
      end
    end
  endgenerate

  // Read mux uses pre-edge register values; unmatched offsets fall through to 0.
  always_comb begin
    w_rd_val = 32'd0;
    if (w_sel_mtl) w_rd_val = r_mtime[31:0];
    if (w_sel_mth) w_rd_val = r_mtime[63:32];
    for (int h = 0; h < N_HARTS; h++) begin
      if (w_sel_msip && (w_req_addr[5:2] == 4'(h)))
        w_rd_val = {31'd0, r_msip[h]};
      if (w_sel_cmp && (w_req_addr[6:3] == 4'(h)))
        w_rd_val = w_req_addr[2] ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
    end
  end

  assign w_rd_fire = w_req_re && !w_req_we;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'd0;
    end else begin
      r_rvalid <= w_rd_fire;
      if (w_rd_fire) r_rdata <= w_rd_val;
    end
  end

  assign w_mtip  = r_mtip;
  assign w_msip  = r_msip;
  assign w_mtime = r_mtime;

endmodule

// File: tb/tb_clint_smp.sv
// Directed self-checking bench: two-hart/TICK_DIV=1 instance plus a one-hart/TICK_DIV=4 instance.
module tb_clint_smp;

  logic        CLK;
  logic        rst_n;
  logic        we, re;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [31:0] a_rdata;
  logic        a_rvalid;
  logic [1:0]  a_mtip, a_msip;
  logic [63:0] a_mtime;

  logic        b_we, b_re;
  logic [15:0] b_addr;
  logic [31:0] b_wdata;
  logic [31:0] b_rdata;
  logic        b_rvalid;
  logic [0:0]  b_mtip, b_msip;
  logic [63:0] b_mtime;

  int unsigned cyc;
  int          checks = 0;
  int          fails  = 0;

  clint_smp #(.N_HARTS(2), .TICK_DIV(1)) dut_a (
    .CLK(CLK), .RST_X(rst_n),
    .w_req_we(we), .w_req_re(re), .w_req_addr(addr), .w_req_wdata(wdata),
    .r_rdata(a_rdata), .r_rvalid(a_rvalid),
    .w_mtip(a_mtip), .w_msip(a_msip), .w_mtime(a_mtime)
  );

  clint_smp #(.N_HARTS(1), .TICK_DIV(4)) dut_b (
    .CLK(CLK), .RST_X(rst_n),
    .w_req_we(b_we), .w_req_re(b_re), .w_req_addr(b_addr), .w_req_wdata(b_wdata),
    .r_rdata(b_rdata), .r_rvalid(b_rvalid),
    .w_mtip(b_mtip), .w_msip(b_msip), .w_mtime(b_mtime)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference count of clock edges since reset release (= expected mtime at TICK_DIV=1).
  always @(posedge CLK or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("ok   %s obs=%h", tag, obs);
    end else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All request tasks start and end on a falling edge.
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge CLK);
    we = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d, output logic v);
    re = 1'b1; addr = a;
    @(negedge CLK);
    re = 1'b0;
    d = a_rdata; v = a_rvalid;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        v;
    int unsigned c0, t;

    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 16'd0; wdata = 32'd0;
    b_we = 1'b0; b_re = 1'b0; b_addr = 16'd0; b_wdata = 32'd0;
    repeat (2) @(negedge CLK);
    chk("rst_rvalid", 64'(a_rvalid), 64'd0);
    chk("rst_rdata",  64'(a_rdata),  64'd0);
    chk("rst_mtime",  a_mtime,       64'd0);
    chk("rst_mtip",   64'(a_mtip),   64'd0);
    chk("rst_msip",   64'(a_msip),   64'd0);
    rst_n = 1'b1;

    rd(16'h4000, d, v); chk("cmp0_lo_rst", 64'(d), 64'hFFFF_FFFF); chk("cmp0_lo_vld", 64'(v), 64'd1);
    rd(16'h4004, d, v); chk("cmp0_hi_rst", 64'(d), 64'hFFFF_FFFF); chk("cmp0_hi_vld", 64'(v), 64'd1);
    chk("mtip_after_rst", 64'(a_mtip), 64'd0);
    chk("msip_after_rst", 64'(a_msip), 64'd0);
    @(negedge CLK);
    chk("rvalid_pulse", 64'(a_rvalid), 64'd0);
    rd(16'h4008, d, v); chk("cmp1_lo_rst", 64'(d), 64'hFFFF_FFFF);
    rd(16'h4010, d, v); chk("cmp2_absent", 64'(d), 64'd0);
    rd(16'h1234, d, v); chk("unmapped_rd", 64'(d), 64'd0);

    // Back-to-back mtime reads
    c0 = cyc;
    re = 1'b1; addr = 16'hBFF8;
    @(negedge CLK);
    chk("b2b_lo_vld", 64'(a_rvalid), 64'd1);
    chk("b2b_lo",     64'(a_rdata),  64'(c0));
    addr = 16'hBFFC;
    @(negedge CLK);
    re = 1'b0;
    chk("b2b_hi_vld", 64'(a_rvalid), 64'd1);
    chk("b2b_hi",     64'(a_rdata),  64'd0);
    @(negedge CLK);
    chk("b2b_end",    64'(a_rvalid), 64'd0);

    // Prescaled instance: 40 edges give mtime 10
    while (cyc < 40) @(negedge CLK);
    b_re = 1'b1; b_addr = 16'hBFF8;
    @(negedge CLK);
    b_re = 1'b0;
    chk("tick4_vld", 64'(b_rvalid), 64'd1);
    chk("tick4_rd",  64'(b_rdata),  64'd10);
    for (int i = 0; i < 8; i++) begin
      chk("tick4_mtime", b_mtime, 64'(cyc / 4));
      @(negedge CLK);
    end
    chk("tick4_mtip", 64'(b_mtip), 64'd0);
    chk("tick4_msip", 64'(b_msip), 64'd0);

    // Timer interrupt on hart 1
    t = cyc + 20;
    wr(16'h4008, t);
    wr(16'h400C, 32'd0);
    while (cyc < t + 3) begin
      chk("tmr_mtime", a_mtime,            64'(cyc));
      chk("tmr_mtip1", 64'(a_mtip[1]),     64'(cyc >= t + 1));
      chk("tmr_mtip0", 64'(a_mtip[0]),     64'd0);
      @(negedge CLK);
    end
    wr(16'h400C, 32'd1);
    chk("tmr_clr_lag", 64'(a_mtip[1]), 64'd1);
    @(negedge CLK);
    chk("tmr_clr",     64'(a_mtip[1]), 64'd0);

    // Software interrupts
    wr(16'h0004, 32'd1);        chk("msip1_set",   64'(a_msip), 64'b10);
    wr(16'h0004, 32'd0);        chk("msip1_clr",   64'(a_msip), 64'b00);
    wr(16'h0008, 32'd1);        chk("msip2_absent", 64'(a_msip), 64'b00);
    rd(16'h0008, d, v);         chk("msip2_rd",    64'(d), 64'd0);
    wr(16'h0000, 32'hFFFF_FFFF); chk("msip0_set",  64'(a_msip), 64'b01);
    rd(16'h0000, d, v);         chk("msip0_rd",    64'(d), 64'd1);
    wr(16'h0000, 32'd0);        chk("msip0_clr",   64'(a_msip), 64'b00);

    // Simultaneous write and read: write wins, no response
    we = 1'b1; re = 1'b1; addr = 16'h0000; wdata = 32'd1;
    @(negedge CLK);
    we = 1'b0; re = 1'b0;
    chk("wr_rd_msip",   64'(a_msip),   64'b01);
    chk("wr_rd_rvalid", 64'(a_rvalid), 64'd0);

    // mtime write and 64-bit wrap
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFE);
`ifdef CLINT_MTIME_WR_EN
    chk("wrap_fe", a_mtime, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge CLK);
    chk("wrap_ff", a_mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge CLK);
    chk("wrap_0",  a_mtime, 64'd0);
    chk("wrap_mtip0_max", 64'(a_mtip[0]), 64'd1);
    @(negedge CLK);
    chk("wrap_1",  a_mtime, 64'd1);
    chk("wrap_mtip0_clr", 64'(a_mtip[0]), 64'd0);
`else
    chk("ro_mtime0", a_mtime, 64'(cyc));
    @(negedge CLK);
    chk("ro_mtime1", a_mtime, 64'(cyc));
    @(negedge CLK);
    chk("ro_mtime2", a_mtime, 64'(cyc));
    chk("ro_mtip0",  64'(a_mtip[0]), 64'd0);
`endif

    // Reset during an outstanding read
    rd(16'h4000, d, v); chk("pre_rst_rd", 64'(d), 64'hFFFF_FFFF);
    re = 1'b1; addr = 16'h4000;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rdata", 64'(a_rdata),  64'd0);
    chk("async_mtime", a_mtime,       64'd0);
    chk("async_msip",  64'(a_msip),   64'd0);
    chk("async_mtip",  64'(a_mtip),   64'd0);
    @(posedge CLK);
    #1;
    chk("midrd_rvalid", 64'(a_rvalid), 64'd0);
    chk("midrd_bmtime", b_mtime,       64'd0);
    @(negedge CLK);
    re = 1'b0;
    rst_n = 1'b1;
    @(negedge CLK);
    chk("post_rst_rvalid", 64'(a_rvalid), 64'd0);
    chk("post_rst_mtime",  a_mtime,       64'd1);
    rd(16'h4004, d, v); chk("post_rst_cmp", 64'(d), 64'hFFFF_FFFF);
    rd(16'h0000, d, v); chk("post_rst_msip", 64'(d), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
